// File: rtl/nco_i2c_slave.sv
// Write-only I2C slave at address 0x6A that loads NCO enable/wave, duty cycle and frequency.
// Latency: bus edge -> internal event 3 clk; outputs commit 1 clk after the final bit-8 rise event.
// Backpressure: none; the I2C master paces everything, and the slave only ACKs by pulling sda low.
`timescale 1ns/1ps
module nco_i2c_slave (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl,
    inout  wire         sda,
    output logic        enable,
    output logic [1:0]  wave,
    output logic [63:0] frequency,
    output logic [15:0] duty_cycle
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_CTRL,
        S_CTRL_ACK,
        S_DATA,
        S_DATA_ACK,
        S_IGNORE
    } state_t;

    // Address byte for a write to 7'h6A
    localparam logic [7:0] ADDR_WR = 8'hD4;

    logic [1:0]  scl_sync_q, sda_sync_q;
    logic        scl_prev_q, sda_prev_q;

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  byte_cnt_q, byte_cnt_d;
    logic [6:0]  shift_q, shift_d;
    logic        fsel_q, fsel_d;
    logic        sda_low_q, sda_low_d;
    logic        enable_q, enable_d;
    logic [1:0]  wave_q, wave_d;
    logic [63:0] freq_q, freq_d;
    logic [63:0] freq_sh_q, freq_sh_d;
    logic [15:0] duty_q, duty_d;
    logic [15:0] duty_sh_q, duty_sh_d;

    logic        scl_s, sda_s;
    logic        scl_rise, scl_fall, start_det, stop_det;
    logic [7:0]  byte_val;
    logic [3:0]  field_len;

    // Two-flop synchronizers plus one history flop for edge detection; idle-high after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl};
            sda_sync_q <= {sda_sync_q[0], sda};
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
        end
    end

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    // sda moving while scl stays high is always a bus condition, never data
    assign start_det = scl_s & scl_prev_q & ~sda_s & sda_prev_q;
    assign stop_det  = scl_s & scl_prev_q & sda_s & ~sda_prev_q;
    assign byte_val  = {shift_q, sda_s};
    assign field_len = fsel_q ? 4'd8 : 4'd2;

    // State, counters, shadows and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 4'd0;
            shift_q    <= 7'd0;
            fsel_q     <= 1'b0;
            sda_low_q  <= 1'b0;
            enable_q   <= 1'b0;
            wave_q     <= 2'b00;
            freq_q     <= 64'h0;
            freq_sh_q  <= 64'h0;
            duty_q     <= 16'h0;
            duty_sh_q  <= 16'h0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            fsel_q     <= fsel_d;
            sda_low_q  <= sda_low_d;
            enable_q   <= enable_d;
            wave_q     <= wave_d;
            freq_q     <= freq_d;
            freq_sh_q  <= freq_sh_d;
            duty_q     <= duty_d;
            duty_sh_q  <= duty_sh_d;
        end
    end

    // Next-state: bus conditions first, then bit shifting, byte decode and ACK sequencing
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        fsel_d     = fsel_q;
        sda_low_d  = sda_low_q;
        enable_d   = enable_q;
        wave_d     = wave_q;
        freq_d     = freq_q;
        freq_sh_d  = freq_sh_q;
        duty_d     = duty_q;
        duty_sh_d  = duty_sh_q;

        if (start_det) begin
            state_d    = S_ADDR;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 4'd0;
            fsel_d     = 1'b0;
            sda_low_d  = 1'b0;
        end else if (stop_det) begin
            state_d    = S_IDLE;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 4'd0;
            sda_low_d  = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_CTRL, S_DATA: begin
                    if (scl_rise) begin
                        shift_d   = byte_val[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == S_ADDR) begin
                                state_d = (byte_val == ADDR_WR) ? S_ADDR_ACK : S_IGNORE;
                            end else if (state_q == S_CTRL) begin
                                enable_d = byte_val[0];
                                wave_d   = byte_val[2:1];
                                fsel_d   = byte_val[3];
                                state_d  = S_CTRL_ACK;
                            end else begin
                                // Bytes past the end of the field are ACKed but dropped
                                if (byte_cnt_q < field_len) begin
                                    byte_cnt_d = byte_cnt_q + 4'd1;
                                    if (fsel_q) begin
                                        freq_sh_d = {freq_sh_q[55:0], byte_val};
                                        if (byte_cnt_q == 4'd7)
                                            freq_d = {freq_sh_q[55:0], byte_val};
                                    end else begin
                                        duty_sh_d = {duty_sh_q[7:0], byte_val};
                                        if (byte_cnt_q == 4'd1)
                                            duty_d = {duty_sh_q[7:0], byte_val};
                                    end
                                end
                                state_d = S_DATA_ACK;
                            end
                        end
                    end
                end
                S_ADDR_ACK, S_CTRL_ACK, S_DATA_ACK: begin
                    // First fall ends bit 8 and starts the ACK; second fall ends the ACK clock
                    if (scl_fall) begin
                        if (!sda_low_q) begin
                            sda_low_d = 1'b1;
                        end else begin
                            sda_low_d = 1'b0;
                            state_d   = (state_q == S_ADDR_ACK) ? S_CTRL : S_DATA;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sda        = sda_low_q ? 1'b0 : 1'bz;
    assign enable     = enable_q;
    assign wave       = wave_q;
    assign frequency  = freq_q;
    assign duty_cycle = duty_q;

endmodule

// File: tb/tb_nco_i2c_slave.sv
// Bench for nco_i2c_slave: bit-banged I2C master, per-byte ACK and output checks against a byte-level model.
// Latency: checks happen after each ACK clock, well past the 3-4 clk internal delays.
// Backpressure: none; the master paces the bus with fixed clk-count phases.
`timescale 1ns/1ps
module tb_nco_i2c_slave;

    logic        clk;
    logic        reset;
    logic        m_scl;
    logic        m_sda;
    wire         sda;
    logic        enable;
    logic [1:0]  wave;
    logic [63:0] frequency;
    logic [15:0] duty_cycle;

    int errors = 0;
    int checks = 0;

    logic        ref_en;
    logic [1:0]  ref_wave;
    logic [63:0] ref_freq;
    logic [15:0] ref_duty;
    logic [7:0]  txq[$];

    nco_i2c_slave dut (
        .clk        (clk),
        .reset      (reset),
        .scl        (m_scl),
        .sda        (sda),
        .enable     (enable),
        .wave       (wave),
        .frequency  (frequency),
        .duty_cycle (duty_cycle)
    );

    assign sda = m_sda ? 1'bz : 1'b0;
    pullup (sda);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_outputs();
        chk("enable", {63'd0, enable}, {63'd0, ref_en});
        chk("wave", {62'd0, wave}, {62'd0, ref_wave});
        chk("frequency", frequency, ref_freq);
        chk("duty_cycle", {48'd0, duty_cycle}, {48'd0, ref_duty});
    endtask

    task automatic i2c_start();
        if (!m_scl) begin
            wait_clk(6); m_sda = 1'b1;
            wait_clk(4); m_scl = 1'b1;
        end
        wait_clk(6); m_sda = 1'b0;
        wait_clk(6); m_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(6); m_sda = 1'b0;
        wait_clk(4); m_scl = 1'b1;
        wait_clk(6); m_sda = 1'b1;
        wait_clk(10);
    endtask

    // One data bit; flags the slave pulling sda low while the master sends a 1
    task automatic send_bit(input logic b, inout logic spur);
        wait_clk(6); m_sda = b;
        wait_clk(4); m_scl = 1'b1;
        wait_clk(4);
        if (b && sda !== 1'b1) spur = 1'b1;
        wait_clk(4); m_scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked, output logic spur);
        spur = 1'b0;
        for (int i = 7; i >= 0; i--) send_bit(b[i], spur);
        wait_clk(6); m_sda = 1'b1;
        wait_clk(4); m_scl = 1'b1;
        wait_clk(4); acked = (sda === 1'b0);
        wait_clk(4); m_scl = 1'b0;
    endtask

    // Sends START + txq; model: only a 0xD4 first byte is accepted, the second byte is
    // control, and the field (2 bytes duty / 8 bytes freq) commits when its last byte lands
    task automatic run_txn(input bit do_stop);
        logic        ok, fs, ack, spur;
        logic [63:0] acc;
        logic [7:0]  b;
        int          need, k;
        i2c_start();
        ok = 1'b0; fs = 1'b0; acc = 64'h0;
        for (int i = 0; i < txq.size(); i++) begin
            b = txq[i];
            send_byte(b, ack, spur);
            if (i == 0) begin
                ok = (b == 8'hD4);
            end else if (ok) begin
                if (i == 1) begin
                    ref_en = b[0]; ref_wave = b[2:1]; fs = b[3];
                end else begin
                    need = fs ? 8 : 2;
                    k = i - 2;
                    if (k < need) begin
                        acc = {acc[55:0], b};
                        if (k == need - 1) begin
                            if (fs) ref_freq = acc;
                            else    ref_duty = acc[15:0];
                        end
                    end
                end
            end
            chk("ack", {63'd0, ack}, {63'd0, ok});
            chk("nodrive", {63'd0, spur}, 64'd0);
            check_outputs();
        end
        if (do_stop) i2c_stop();
    endtask

    initial begin
        logic spur;
        int   n;
        bit   st;
        m_scl = 1'b1; m_sda = 1'b1; reset = 1'b1;
        ref_en = 1'b0; ref_wave = 2'b00; ref_freq = 64'h0; ref_duty = 16'h0;
        wait_clk(5);
        reset = 1'b0;
        wait_clk(5);
        chk("reset_sda", {63'd0, sda}, 64'd1);
        check_outputs();

        // Directed transactions
        txq = '{8'hD4};                                   run_txn(1);
        txq = '{8'hD4, 8'h01};                            run_txn(1);
        txq = '{8'hD4, 8'h02, 8'h2A, 8'h10};              run_txn(1);
        txq = '{8'hD4, 8'h08, 8'h00, 8'h1A, 8'h23, 8'h33,
                8'hFE, 8'h89, 8'h50, 8'h01};              run_txn(1);
        chk("freq_directed", frequency, 64'h001A2333FE895001);
        chk("duty_directed", {48'd0, duty_cycle}, 64'h2A10);
        txq = '{8'hD6, 8'hFF};                            run_txn(1);
        txq = '{8'hD5, 8'hFF};                            run_txn(1);
        // Repeated START mid-field, then extra bytes past the end of a duty field
        txq = '{8'hD4, 8'h04, 8'h77};                     run_txn(0);
        txq = '{8'hD4, 8'h05, 8'hBE, 8'hEF, 8'h55, 8'h66}; run_txn(1);

        // Randomized transactions
        for (int t = 0; t < 15; t++) begin
            txq.delete();
            if ($urandom_range(0, 3) == 0) txq.push_back(8'($urandom_range(0, 255)));
            else                          txq.push_back(8'hD4);
            txq.push_back(8'($urandom));
            n = $urandom_range(0, 10);
            for (int j = 0; j < n; j++) txq.push_back(8'($urandom));
            st = (t == 14) ? 1'b1 : ($urandom_range(0, 3) != 0);
            run_txn(st);
        end

        // Frequency write cut short by STOP, then reset in the middle of a byte
        txq = '{8'hD4, 8'h08, 8'hAA, 8'hBB, 8'hCC};       run_txn(1);
        i2c_start();
        spur = 1'b0;
        for (int i = 0; i < 4; i++) send_bit(1'b1, spur);
        reset = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        m_scl = 1'b1;
        wait_clk(4);
        m_sda = 1'b1;
        wait_clk(10);
        ref_en = 1'b0; ref_wave = 2'b00; ref_freq = 64'h0; ref_duty = 16'h0;
        chk("post_reset_sda", {63'd0, sda}, 64'd1);
        check_outputs();
        txq = '{8'hD4, 8'h03, 8'h12, 8'h34};              run_txn(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
